life_loader_8x8: RTL and testbench
==================================

# life_loader_8x8

Front-end controller for the 8x8 life array. It accepts a byte stream (host/UART side) with a valid/ready handshake and assembles 9-byte load frames into four 16-bit tile words. It writes those words into the array's tile write port (value, selector, write enable). It also generates the array's `step` pulse, either free-running at a programmable period or one step per request.

## Interface
Parameters:
- `STEP_DIV`, 25_000_000 — clock cycles between free-run steps; legal range 2..2^DIV_W-1.
- `DIV_W`, 32 — width of the step divider counter.

Ports:
- `clk`  in  1  — single system clock; all logic on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `byte_in`  in  8  — incoming stream byte.
- `byte_valid`  in  1  — `byte_in` is valid this cycle.
- `byte_ready`  out  1  — block can accept a byte this cycle.
- `run`  in  1  — level; 1 = free-run stepping.
- `single`  in  1  — level from a debounced button; a rising edge requests one step.
- `vali`  out  16  — tile word to the array.
- `vali_selector`  out  2  — target tile index 0..3.
- `write_enb`  out  1  — one-cycle tile write strobe.
- `step`  out  1  — one-cycle generation-advance pulse.
- `loading`  out  1  — a frame is in progress (state not IDLE).
- `load_done`  out  1  — one-cycle pulse after the 4th tile write.

## Operation
- A byte is accepted on any cycle with `byte_valid & byte_ready`.
- Frame format: header `0xA5`, then 8 data bytes. The data bytes are tiles 0,1,2,3 in order, two bytes per tile, low byte first.
- Tile word = {hi, lo}. It is passed unaltered to `vali`; the bit-to-cell mapping belongs to the array.
- FSM states:
  - IDLE: `byte_ready`=1. An accepted `0xA5` moves to LO and clears the tile index. Any other accepted byte is discarded; stay in IDLE.
  - LO: `byte_ready`=1. An accepted byte is latched as the low byte; go to HI.
  - HI: `byte_ready`=1. An accepted byte is latched as the high byte; go to WRITE.
  - WRITE: `byte_ready`=0. `write_enb`=1, `vali`={hi,lo}, `vali_selector`=tile index.
    - If index=3, go to DONE.
    - Otherwise increment the index and go to LO.
  - DONE: `byte_ready`=0, `load_done`=1; go to IDLE.
- Inside a frame, `0xA5` is ordinary data; there is no resync.
- The FSM has no timeout: a stalled frame waits indefinitely.
- `loading` = (state ≠ IDLE).
- Step generator:
  - `run`=1 and IDLE: the divider counts 0..STEP_DIV-1. At the terminal count, `step`=1 and the divider wraps to 0.
  - `run`=0, or state ≠ IDLE: the divider is held at 0 and free-run steps are suppressed.
  - `single`: a rising-edge detector with a 1-cycle registered history.
    - An edge seen while `run`=0 and state=IDLE produces exactly one `step` pulse.
    - An edge seen while `run`=1 or state ≠ IDLE is dropped; it is not queued.
- `step` and `write_enb` are never high in the same cycle.
- Simultaneous header acceptance and divider terminal count: `step` fires that cycle (state is still IDLE), and loading starts next cycle.

## Timing
- All outputs are registered except `byte_ready` and `loading`, which decode state directly.
- Reset values:
  - state IDLE, so `byte_ready`=1 and `loading`=0.
  - `vali`=0, `vali_selector`=0, `write_enb`=0, `step`=0, `load_done`=0.
  - divider=0, tile index=0, `single` history=0.
- Header accepted at cycle t: state=LO at t+1.
- HI byte accepted at cycle t: `write_enb`=1 at t+1; the next LO byte can be accepted from t+2.
- `vali` and `vali_selector` are stable in the `write_enb` cycle and hold their value until the next write.
- Minimum frame: 9 accept cycles + 4 WRITE + 1 DONE = 14 cycles. `load_done` is high in the cycle after the tile-3 write.
- Free-run: with `run` raised at cycle t (IDLE), the first `step` is at t+STEP_DIV, then every STEP_DIV cycles.
- `single` rising at cycle t (sampled): `step`=1 at t+1.
- Reset asserted mid-frame: the partial frame is abandoned and the block returns to reset values the next cycle. Tiles already written are not undone by this block.

## Test plan
- Reset release → `byte_ready`=1, `loading`=0, all other outputs 0; with `run`=0 and no stimulus, no `step` for 100 cycles.
- Frame A5,34,12,78,56,BC,9A,F0,DE → four `write_enb` pulses (one per tile, never in consecutive cycles), with `vali`/`vali_selector` = 0x1234/0, 0x5678/1, 0x9ABC/2, 0xDEF0/3. Then one `load_done` pulse; `byte_ready`=0 in each WRITE/DONE cycle.
- Garbage bytes 00,FF,5A before the header → discarded, no writes. Frame with data byte `0xA5` → written as data; tile 0 = 0xA5A5 when lo=hi=A5.
- STEP_DIV=4 override, `run`=1 for 20 cycles → `step` at cycles 4,8,12,16,20 after `run`. A header arriving mid-run → steps stop while `loading`=1, divider restarts from 0 after DONE.
- `run`=0, `single` toggled 0→1 and held for 10 cycles → exactly one `step`. A `single` edge during a frame or with `run`=1 → no extra `step`.
- Reset asserted after 5 frame bytes → returns to IDLE. A following full frame writes tiles 0..3 correctly starting from index 0.

Source files
------------

// File: rtl/life_loader_8x8_if.sv
// Byte-stream, step-control and tile-write signals of the 8x8 life array loader.
interface life_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        run;
  logic        single;
  logic [15:0] vali;
  logic [1:0]  vali_selector;
  logic        write_enb;
  logic        step;
  logic        loading;
  logic        load_done;

  // Host side: drives the stream and step controls, observes the array-side outputs
  modport master (
    output byte_in, byte_valid, run, single,
    input  byte_ready, vali, vali_selector, write_enb, step, loading, load_done
  );

  // Loader side
  modport slave (
    input  byte_in, byte_valid, run, single,
    output byte_ready, vali, vali_selector, write_enb, step, loading, load_done
  );
endinterface

// File: rtl/life_loader_8x8.sv
// Front-end for the 8x8 life array: assembles 0xA5-headed 9-byte frames into four
// 16-bit tile writes and generates the free-run / single-shot step pulse.
module life_loader_8x8 #(
  parameter int unsigned STEP_DIV = 25_000_000,
  parameter int unsigned DIV_W    = 32
) (
  input logic          clk,
  input logic          reset,
  life_loader_if.slave bus
);

  localparam logic [2:0]       S_IDLE    = 3'd0;
  localparam logic [2:0]       S_LO      = 3'd1;
  localparam logic [2:0]       S_HI      = 3'd2;
  localparam logic [2:0]       S_WRITE   = 3'd3;
  localparam logic [2:0]       S_DONE    = 3'd4;
  localparam logic [7:0]       HEADER    = 8'hA5;
  localparam logic [1:0]       LAST_TILE = 2'd3;
  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(STEP_DIV - 1);

  logic [2:0]       r_state;
  logic [1:0]       r_idx;
  logic [7:0]       r_lo;
  logic [15:0]      r_vali;
  logic [1:0]       r_sel;
  logic             r_we;
  logic             r_step;
  logic             r_done;
  logic [DIV_W-1:0] r_div;
  logic             r_single_d;

  logic [2:0]       w_state_nxt;
  logic [1:0]       w_idx_nxt;
  logic [7:0]       w_lo_nxt;
  logic [15:0]      w_vali_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_we_nxt;
  logic             w_step_nxt;
  logic             w_done_nxt;
  logic [DIV_W-1:0] w_div_nxt;

  logic             w_ready;
  logic             w_accept;
  logic             w_idle;
  logic             w_edge;
  logic             w_tc;

  // Handshake and status decode straight from state
  assign w_idle   = (r_state == S_IDLE);
  assign w_ready  = (r_state == S_IDLE) || (r_state == S_LO) || (r_state == S_HI);
  assign w_accept = bus.byte_valid && w_ready;
  assign w_edge   = bus.single && !r_single_d;
  assign w_tc     = (r_div == DIV_TC);

  // Next state plus next values of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lo_nxt    = r_lo;
    w_vali_nxt  = r_vali;
    w_sel_nxt   = r_sel;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_step_nxt  = 1'b0;
    w_div_nxt   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_accept && (bus.byte_in == HEADER)) begin
          w_state_nxt = S_LO;
          w_idx_nxt   = 2'd0;
        end
      end
      S_LO: begin
        if (w_accept) begin
          w_lo_nxt    = bus.byte_in;
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        // Output word is registered here so it is valid in the WRITE cycle
        if (w_accept) begin
          w_vali_nxt  = {bus.byte_in, r_lo};
          w_sel_nxt   = r_idx;
          w_we_nxt    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_idx == LAST_TILE) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = S_LO;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Stepping only advances while idle; a loading frame freezes the divider at 0
    if (w_idle && bus.run) begin
      w_div_nxt  = w_tc ? '0 : (r_div + DIV_W'(1));
      w_step_nxt = w_tc;
    end else if (w_idle && w_edge) begin
      w_step_nxt = 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_lo       <= 8'd0;
      r_vali     <= 16'd0;
      r_sel      <= 2'd0;
      r_we       <= 1'b0;
      r_step     <= 1'b0;
      r_done     <= 1'b0;
      r_div      <= '0;
      r_single_d <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_lo       <= w_lo_nxt;
      r_vali     <= w_vali_nxt;
      r_sel      <= w_sel_nxt;
      r_we       <= w_we_nxt;
      r_step     <= w_step_nxt;
      r_done     <= w_done_nxt;
      r_div      <= w_div_nxt;
      r_single_d <= bus.single;
    end
  end

  assign bus.byte_ready    = w_ready;
  assign bus.loading       = !w_idle;
  assign bus.vali          = r_vali;
  assign bus.vali_selector = r_sel;
  assign bus.write_enb     = r_we;
  assign bus.step          = r_step;
  assign bus.load_done     = r_done;

endmodule

// File: tb/tb_life_loader_8x8.sv
// Bench for life_loader_8x8: byte-stream frame model plus directed step-timing vectors.
module tb_life_loader_8x8;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  life_loader_if u_if ();

  life_loader_8x8 #(.STEP_DIV(4), .DIV_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- frame model and compare process ----------------
  bit          m_in_frame;
  int          m_cnt;
  logic [7:0]  m_lo;
  logic [17:0] exp_q[$];
  int          m_frames;
  int          done_cnt;
  int          done_cyc;
  logic [15:0] m_last_v;
  logic [1:0]  m_last_s;
  bit          prev_we;
  logic [15:0] act_v[$];
  logic [1:0]  act_s[$];
  int          step_log[$];
  logic [17:0] e;

  initial begin
    m_in_frame = 0; m_cnt = 0; m_lo = 0; m_frames = 0; done_cnt = 0; done_cyc = 0;
    m_last_v = 0; m_last_s = 0; prev_we = 0;
  end

  // Sample outputs mid-cycle; predict tile writes from the accepted byte stream
  always @(negedge clk) begin
    if (reset) begin
      m_in_frame = 0; m_cnt = 0; m_lo = 0; m_frames = 0; done_cnt = 0;
      m_last_v = 0; m_last_s = 0; prev_we = 0;
      exp_q.delete();
    end else begin
      if (u_if.write_enb) begin
        act_v.push_back(u_if.vali);
        act_s.push_back(u_if.vali_selector);
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tile_word", 32'({u_if.vali_selector, u_if.vali}), 32'(e));
          m_last_s = e[17:16];
          m_last_v = e[15:0];
        end
        chk("write_cycle_ctl", 32'({prev_we, u_if.byte_ready, u_if.step}), 32'd0);
      end else begin
        chk("vali_hold", 32'({u_if.vali_selector, u_if.vali}), 32'({m_last_s, m_last_v}));
      end
      if (u_if.load_done) begin
        chk("done_ctl", 32'({u_if.byte_ready, u_if.loading, m_frames > done_cnt}), 32'd3);
        done_cnt++;
        done_cyc = cyc;
      end
      if (u_if.step) step_log.push_back(cyc);
      prev_we = u_if.write_enb;
      if (u_if.byte_valid && u_if.byte_ready) begin
        if (!m_in_frame) begin
          if (u_if.byte_in == 8'hA5) begin
            m_in_frame = 1;
            m_cnt = 0;
          end
        end else begin
          if (m_cnt % 2 == 0) m_lo = u_if.byte_in;
          else exp_q.push_back({2'(m_cnt / 2), u_if.byte_in, m_lo});
          m_cnt++;
          if (m_cnt == 8) begin
            m_in_frame = 0;
            m_frames++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    bit acc;
    acc = 0;
    u_if.byte_in = b;
    u_if.byte_valid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      rdy = u_if.byte_ready;
      tick();
      if (rdy) acc = 1;
    end
    u_if.byte_valid = 1'b0;
    chk("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8);
    logic [7:0] bs [8];
    bs = '{b1, b2, b3, b4, b5, b6, b7, b8};
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) send_byte(bs[i]);
  endtask

  task automatic wait_done();
    int s;
    int n;
    s = done_cnt;
    n = 0;
    while (done_cnt == s && n < 100) begin
      tick();
      n++;
    end
    chk("load_done_seen", 32'(done_cnt != s), 32'd1);
  endtask

  task automatic chk_frame(input string nm, input int mark, input logic [15:0] w0, w1, w2, w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    chk({nm, "_count"}, 32'(act_v.size() - mark), 32'd4);
    for (int i = 0; i < 4; i++)
      if (mark + i < act_v.size())
        chk(nm, 32'({act_s[mark+i], act_v[mark+i]}), 32'({2'(i), w[i]}));
  endtask

  task automatic chk_steps(input string nm, input int mark, input int n, input int base,
                           input int o0, o1, o2, o3, o4);
    int o [5];
    o = '{o0, o1, o2, o3, o4};
    chk({nm, "_count"}, 32'(step_log.size() - mark), 32'(n));
    for (int i = 0; i < n && i < 5; i++)
      if (mark + i < step_log.size())
        chk(nm, 32'(step_log[mark+i] - base), 32'(o[i]));
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, 32'(u_if.byte_ready), 32'd1);
    chk({nm, "_loading"}, 32'(u_if.loading), 32'd0);
    chk({nm, "_outs"}, 32'({u_if.vali, u_if.vali_selector, u_if.write_enb, u_if.step,
                            u_if.load_done}), 32'd0);
    tick();
  endtask

  // Watchdog in case a stimulus loop never returns
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=%0d required=<2000000ns", $time);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int mark;
    int amark;
    int run_t;
    int s_t;
    int d;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    u_if.byte_in = 8'h00;
    u_if.byte_valid = 1'b0;
    u_if.run = 1'b0;
    u_if.single = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_state("reset");

    // Idle with run=0: no steps
    mark = step_log.size();
    repeat (100) tick();
    chk_steps("idle_steps", mark, 0, 0, 0, 0, 0, 0, 0);

    // Basic frame
    amark = act_v.size();
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE);
    wait_done();
    chk_frame("frame_a", amark, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);

    // Garbage before header, then 0xA5 used as data
    amark = act_v.size();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    repeat (3) tick();
    chk("garbage_nowrite", 32'(act_v.size() - amark), 32'd0);
    chk("garbage_idle", 32'(u_if.loading), 32'd0);
    send_frame(8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    wait_done();
    chk_frame("frame_a5", amark, 16'hA5A5, 16'h01A5, 16'h0302, 16'h0504);

    // Free-run, STEP_DIV=4
    u_if.run = 1'b1;
    run_t = cyc;
    mark = step_log.size();
    while (cyc < run_t + 20) tick();
    u_if.run = 1'b0;
    repeat (3) tick();
    chk_steps("freerun", mark, 5, run_t, 4, 8, 12, 16, 20);

    // Header mid-run: steps pause while loading, divider restarts after DONE
    u_if.run = 1'b1;
    run_t = cyc;
    mark = step_log.size();
    while (cyc < run_t + 5) tick();
    amark = act_v.size();
    send_frame(8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE);
    wait_done();
    d = done_cyc;
    while (cyc < d + 10) tick();
    u_if.run = 1'b0;
    repeat (3) tick();
    chk_frame("frame_run", amark, 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC);
    chk_steps("run_load", mark, 3, run_t, 4, d + 5 - run_t, d + 9 - run_t, 0, 0);

    // Single-step: one pulse per rising edge
    u_if.single = 1'b1;
    s_t = cyc;
    mark = step_log.size();
    repeat (10) tick();
    u_if.single = 1'b0;
    repeat (3) tick();
    chk_steps("single", mark, 1, s_t, 1, 0, 0, 0, 0);

    // Single edge during a frame is dropped
    mark = step_log.size();
    amark = act_v.size();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    u_if.single = 1'b1;
    repeat (3) tick();
    u_if.single = 1'b0;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    wait_done();
    repeat (3) tick();
    chk_steps("single_loading", mark, 0, 0, 0, 0, 0, 0, 0);
    chk_frame("frame_single", amark, 16'h0201, 16'h0403, 16'h0605, 16'h0807);

    // Single edge while run=1 is dropped
    u_if.run = 1'b1;
    run_t = cyc;
    mark = step_log.size();
    tick();
    u_if.single = 1'b1;
    while (cyc < run_t + 9) tick();
    u_if.run = 1'b0;
    repeat (2) tick();
    u_if.single = 1'b0;
    repeat (3) tick();
    chk_steps("single_run", mark, 2, run_t, 4, 8, 0, 0, 0);

    // Reset after 5 frame bytes, then a clean frame from tile 0
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("midreset");
    amark = act_v.size();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
    wait_done();
    chk_frame("frame_after_rst", amark, 16'h0201, 16'h0403, 16'h0605, 16'h0807);

    repeat (5) tick();
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
